// File: rtl/csa_stream_accumulator_pkg.sv
// Shared definitions for the carry-save stream accumulator:
// FSM states, default widths and accumulator width derivation.
package csa_stream_accumulator_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Headroom of cnt_w bits holds the exact sum of 2^cnt_w maximal operands.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned cnt_w);
        return width + cnt_w;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_row.sv
// Combinational N-bit 3:2 compressor row: bitwise full adders with no carry ripple.
module csa_row #(
    parameter int unsigned N = 36
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum_c,
    output logic [N-1:0] carry_c
);

    assign sum_c   = a ^ b ^ c;
    assign carry_c = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Accumulates a valid/ready operand stream in carry-save form and resolves
// the exact group total with one carry-propagate add on the closing beat.
module csa_stream_accumulator
    import csa_stream_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [acc_w(WIDTH,CNT_W)-1:0] out_sum,
    output logic [CNT_W:0]              out_beats,
    output logic                        out_forced
);

    localparam int unsigned ACC_W   = acc_w(WIDTH, CNT_W);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    state_e             state;
    logic [ACC_W-1:0]   s_q;
    logic [ACC_W-1:0]   c_q;
    logic [CNT_W:0]     cnt_q;
    logic               forced_q;

    logic [ACC_W-1:0]   c_shift;
    logic [ACC_W-1:0]   d_ext;
    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic               accept;
    logic               at_limit;

    // Carry vector is stored unshifted; its weight is applied on use.
    assign c_shift  = {c_q[ACC_W-2:0], 1'b0};
    assign d_ext    = ACC_W'(in_data);
    assign accept   = in_valid & in_ready;
    assign at_limit = (cnt_q == (CNT_W+1)'(CNT_MAX));

    csa_row #(.N(ACC_W)) u_row (
        .a       (s_q),
        .b       (c_shift),
        .c       (d_ext),
        .sum_c   (row_sum),
        .carry_c (row_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            s_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
            forced_q   <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_beats  <= '0;
            out_forced <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        s_q   <= row_sum;
                        c_q   <= row_carry;
                        cnt_q <= cnt_q + (CNT_W+1)'(1);
                        if (in_last || at_limit) begin
                            forced_q <= ~in_last;
                            in_ready <= 1'b0;
                            state    <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum    <= s_q + c_shift;
                    out_beats  <= cnt_q;
                    out_forced <= forced_q;
                    out_valid  <= 1'b1;
                    state      <= OUTPUT;
                end
                OUTPUT: begin
                    // Handover cycle: in_ready rises only once back in ACCUM.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        s_q       <= '0;
                        c_q       <= '0;
                        cnt_q     <= '0;
                        forced_q  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator with hand-computed group totals.
module tb_csa_stream_accumulator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = WIDTH + CNT_W;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [CNT_W:0]     out_beats;
    logic               out_forced;

    int checks = 0;
    int errors = 0;

    csa_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_beats  (out_beats),
        .out_forced (out_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic expect_result(input string tag, input logic [ACC_W-1:0] s,
                                 input int unsigned b, input logic f);
        int t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"},  64'(out_valid),  64'd1);
        check({tag, "_sum"},    64'(out_sum),    64'(s));
        check({tag, "_beats"},  64'(out_beats),  64'(b));
        check({tag, "_forced"}, 64'(out_forced), 64'(f));
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop"},   64'(out_valid),  64'd0);
    endtask

    task automatic pulse_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_out_valid"},  64'(out_valid),  64'd0);
        check({tag, "_out_sum"},    64'(out_sum),    64'd0);
        check({tag, "_out_beats"},  64'(out_beats),  64'd0);
        check({tag, "_out_forced"}, 64'(out_forced), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready",   64'(in_ready),   64'd0);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_sum",    64'(out_sum),    64'd0);
        check("rst_out_beats",  64'(out_beats),  64'd0);
        check("rst_out_forced", 64'(out_forced), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Group {5,7,9}: latency and throughput with out_ready held high.
        send_beat(32'd5, 1'b0);
        send_beat(32'd7, 1'b0);
        send_beat(32'd9, 1'b1);
        check("g1_lat_n",     64'(out_valid), 64'd0);
        check("g1_ready_res", 64'(in_ready),  64'd0);
        @(negedge clk);
        check("g1_lat_n1",    64'(out_valid), 64'd1);
        check("g1_ready_out", 64'(in_ready),  64'd0);
        expect_result("g1", 36'd21, 3, 1'b0);
        check("g1_ready_back", 64'(in_ready), 64'd1);

        // Single maximal beat closed by in_last on the first beat.
        send_beat(32'hFFFF_FFFF, 1'b1);
        expect_result("g2", 36'h0_FFFF_FFFF, 1, 1'b0);

        // 16 maximal beats without in_last: closed by the counter limit.
        for (int i = 0; i < 16; i++) send_beat(32'hFFFF_FFFF, 1'b0);
        check("g3_ready_closed", 64'(in_ready), 64'd0);
        expect_result("g3", 36'hF_FFFF_FFF0, 16, 1'b1);

        // Downstream stall: result must hold and no beat may sneak in.
        out_ready = 1'b0;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd100;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("g4_stall_valid", 64'(out_valid), 64'd1);
            check("g4_stall_sum",   64'(out_sum),   64'd3);
            check("g4_stall_ready", 64'(in_ready),  64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("g4", 36'd3, 2, 1'b0);
        send_beat(32'd10, 1'b1);
        expect_result("g4b", 36'd10, 1, 1'b0);

        // Bubbles: invalid cycles carry junk data and a stray in_last.
        in_valid = 1'b1; in_data = 32'd4; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd6; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_data = 32'hFFFF_FFFF; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd8; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("g5", 36'd18, 3, 1'b0);

        // Reset mid-group drops the partial sum.
        send_beat(32'd50, 1'b0);
        send_beat(32'd60, 1'b0);
        pulse_reset_check("r1");
        send_beat(32'd3, 1'b1);
        expect_result("g6", 36'd3, 1, 1'b0);

        // Reset while a result is pending drops it entirely.
        out_ready = 1'b0;
        send_beat(32'd7, 1'b1);
        @(negedge clk);
        check("r2_pending", 64'(out_valid), 64'd1);
        pulse_reset_check("r2");
        for (int i = 0; i < 3; i++) begin
            check("r2_no_out", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send_beat(32'd3, 1'b1);
        expect_result("g7", 36'd3, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
